// File: rtl/decode_stage_if.sv
// Handshake, writeback and ID/EX result bundle for decode_stage.
// The master side is the fetch/writeback/execute environment and the slave side is the stage.
interface decode_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [31:0]       in_instr;
    logic [DATA_W-1:0] in_pc;
    logic              in_ready;
    logic              flush;

    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_pc;
    logic [5:0]        out_opcode;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [4:0]        out_rd;
    logic [4:0]        out_shamt;
    logic [5:0]        out_funct;
    logic [DATA_W-1:0] out_imm;
    logic [25:0]       out_jaddr;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic              out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, flush,
        output wb_en, wb_addr, wb_data,
        output out_ready,
        input  in_ready,
        input  out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd, out_shamt,
        input  out_funct, out_imm, out_jaddr, out_rs_data, out_rt_data, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush,
        input  wb_en, wb_addr, wb_data,
        input  out_ready,
        output in_ready,
        output out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd, out_shamt,
        output out_funct, out_imm, out_jaddr, out_rs_data, out_rt_data, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: field split, immediate sign-extension, legality check,
// two-port register-file read and ID/EX output register. Optional macro: DECODE_BYPASS_EN.
module decode_stage #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic           clock,
    input  logic           reset,
    decode_stage_if.slave  bus
);

    // Decode helpers

    function automatic logic [DATA_W-1:0] sext_imm(input logic [15:0] imm);
        logic [DATA_W-1:0] res;
        res = '0;
        for (int i = 0; i < DATA_W; i++) begin
            res[i] = (i < 16) ? imm[i[3:0]] : imm[15];
        end
        return res;
    endfunction

    function automatic logic is_illegal(input logic [5:0] opcode, input logic [5:0] funct);
        logic bad;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: bad = 1'b0;
                    default:                                                bad = 1'b1;
                endcase
            end
            6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
            6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: bad = 1'b0;
            default:                            bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Architectural state

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_pc;
    logic [5:0]        r_out_opcode;
    logic [4:0]        r_out_rs;
    logic [4:0]        r_out_rt;
    logic [4:0]        r_out_rd;
    logic [4:0]        r_out_shamt;
    logic [5:0]        r_out_funct;
    logic [DATA_W-1:0] r_out_imm;
    logic [25:0]       r_out_jaddr;
    logic [DATA_W-1:0] r_out_rs_data;
    logic [DATA_W-1:0] r_out_rt_data;
    logic              r_out_illegal;

    // Combinational decode of the incoming word

    logic [5:0]        w_opcode;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [4:0]        w_shamt;
    logic [5:0]        w_funct;
    logic [25:0]       w_jaddr;
    logic [DATA_W-1:0] w_imm;
    logic              w_illegal;
    logic [DATA_W-1:0] w_rs_rf;
    logic [DATA_W-1:0] w_rt_rf;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic              w_wb_ok;
    logic              w_in_ready;
    logic              w_accept;

    // Field split, immediate extension and legality of the presented instruction
    always_comb begin
        w_opcode  = bus.in_instr[31:26];
        w_rs      = bus.in_instr[25:21];
        w_rt      = bus.in_instr[20:16];
        w_rd      = bus.in_instr[15:11];
        w_shamt   = bus.in_instr[10:6];
        w_funct   = bus.in_instr[5:0];
        w_jaddr   = bus.in_instr[25:0];
        w_imm     = sext_imm(bus.in_instr[15:0]);
        w_illegal = is_illegal(bus.in_instr[31:26], bus.in_instr[5:0]);
    end

    // Handshake: a writeback only lands on an implemented, non-zero register
    always_comb begin
        w_wb_ok    = bus.wb_en && (bus.wb_addr != 5'd0) && (int'(bus.wb_addr) < NUM_REGS);
        w_in_ready = !r_out_valid || bus.out_ready;
        w_accept   = bus.in_valid && w_in_ready;
    end

    // Register-file read mux; r0 and unimplemented addresses read as zero
    always_comb begin
        w_rs_rf = '0;
        w_rt_rf = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_rs_rf = (int'(w_rs) == i) ? r_regs[i] : w_rs_rf;
            w_rt_rf = (int'(w_rt) == i) ? r_regs[i] : w_rt_rf;
        end
    end

    // Operand selection, optionally forwarding a same-cycle writeback
    always_comb begin
`ifdef DECODE_BYPASS_EN
        w_rs_val = (w_wb_ok && (bus.wb_addr == w_rs)) ? bus.wb_data : w_rs_rf;
        w_rt_val = (w_wb_ok && (bus.wb_addr == w_rt)) ? bus.wb_data : w_rt_rf;
`else
        w_rs_val = w_rs_rf;
        w_rt_val = w_rt_rf;
`endif
    end

    // Register-file write port; entry 0 is never written so it stays zero
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_wb_ok && (int'(bus.wb_addr) == i)) begin
                    r_regs[i] <= bus.wb_data;
                end else begin
                    r_regs[i] <= r_regs[i];
                end
            end
        end
    end

    // ID/EX output register: flush beats accept, accept beats drain/hold
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_out_valid   <= 1'b0;
            r_out_pc      <= '0;
            r_out_opcode  <= 6'd0;
            r_out_rs      <= 5'd0;
            r_out_rt      <= 5'd0;
            r_out_rd      <= 5'd0;
            r_out_shamt   <= 5'd0;
            r_out_funct   <= 6'd0;
            r_out_imm     <= '0;
            r_out_jaddr   <= 26'd0;
            r_out_rs_data <= '0;
            r_out_rt_data <= '0;
            r_out_illegal <= 1'b0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_pc      <= bus.in_pc;
            r_out_opcode  <= w_opcode;
            r_out_rs      <= w_rs;
            r_out_rt      <= w_rt;
            r_out_rd      <= w_rd;
            r_out_shamt   <= w_shamt;
            r_out_funct   <= w_funct;
            r_out_imm     <= w_imm;
            r_out_jaddr   <= w_jaddr;
            r_out_rs_data <= w_rs_val;
            r_out_rt_data <= w_rt_val;
            r_out_illegal <= w_illegal;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
`ifdef DECODE_BYPASS_EN
            // A stalled instruction keeps its operands coherent with later writebacks
            if (r_out_valid && w_wb_ok && (bus.wb_addr == r_out_rs)) begin
                r_out_rs_data <= bus.wb_data;
            end else begin
                r_out_rs_data <= r_out_rs_data;
            end
            if (r_out_valid && w_wb_ok && (bus.wb_addr == r_out_rt)) begin
                r_out_rt_data <= bus.wb_data;
            end else begin
                r_out_rt_data <= r_out_rt_data;
            end
`endif
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_pc      = r_out_pc;
    assign bus.out_opcode  = r_out_opcode;
    assign bus.out_rs      = r_out_rs;
    assign bus.out_rt      = r_out_rt;
    assign bus.out_rd      = r_out_rd;
    assign bus.out_shamt   = r_out_shamt;
    assign bus.out_funct   = r_out_funct;
    assign bus.out_imm     = r_out_imm;
    assign bus.out_jaddr   = r_out_jaddr;
    assign bus.out_rs_data = r_out_rs_data;
    assign bus.out_rt_data = r_out_rt_data;
    assign bus.out_illegal = r_out_illegal;

endmodule
